shift_left: RTL and testbench

//  - ID-stage logical left shifter for the 16-bit operand selected by mux3.
//  - Primary use: scale a sign-extended immediate or branch offset into a byte offset (x2).
//  - The combinational result feeds the branch-target adder in the same cycle.
//  - A registered copy with a valid flag and an overflow flag is provided for pipelined consumers.

---
 rtl/shift_pkg.sv | 8 +
 rtl/shift_left_core.sv | 38 +++
 rtl/shift_left.sv | 61 ++++++
 tb/tb_shift_left.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared ID-stage word definitions used by the shifter and the branch adders.
package shift_pkg;

  localparam int WORD_W = 16;

  typedef logic [WORD_W-1:0] word_t;

endpackage : shift_pkg

// File: rtl/shift_left_core.sv
// Combinational logical left barrel shifter with a fixed shift amount.
// One stage per bit of the shift amount. A stage whose bit is clear passes
// its input through unchanged. Every stage that shifts ORs the bits it drops
// into a running overflow term.
module shift_left_core
  import shift_pkg::*;
#(
  parameter int WIDTH = WORD_W,
  parameter int SHAMT = 1
) (
  input  logic [WIDTH-1:0] operand,
  output logic [WIDTH-1:0] result,
  output logic             ovf
);

  localparam int NSTG = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0] stg_data [NSTG+1];
  logic             stg_ovf  [NSTG+1];

  assign stg_data[0] = operand;
  assign stg_ovf[0]  = 1'b0;

  for (genvar k = 0; k < NSTG; k++) begin : g_stage
    localparam int AMT = 1 << k;
    if (((SHAMT >> k) & 1) == 1) begin : g_shift
      assign stg_data[k+1] = stg_data[k] << AMT;
      assign stg_ovf[k+1]  = stg_ovf[k] | (|stg_data[k][WIDTH-1 -: AMT]);
    end else begin : g_pass
      assign stg_data[k+1] = stg_data[k];
      assign stg_ovf[k+1]  = stg_ovf[k];
    end
  end

  assign result = stg_data[NSTG];
  assign ovf    = stg_ovf[NSTG];

endmodule : shift_left_core

// File: rtl/shift_left.sv
// ID-stage left shifter. It scales the mux3 operand for the branch-target adder.
// shift_out is combinational and is used in the same cycle. A registered copy,
// together with valid and overflow flags, feeds later pipeline consumers.
module shift_left
  import shift_pkg::*;
#(
  parameter int WIDTH = WORD_W,
  parameter int SHAMT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] mux3output,
  input  logic             in_valid,
  output logic [WIDTH-1:0] shift_out,
  output logic [WIDTH-1:0] shift_out_q,
  output logic             out_valid,
  output logic             ovf_q
);

  if (WIDTH < 2 || SHAMT < 0 || SHAMT >= WIDTH) begin : g_bad_params
    $error("shift_left: need WIDTH >= 2 and 0 <= SHAMT < WIDTH");
  end

  logic [WIDTH-1:0] shift_p0;
  logic             ovf_p0;
  logic [WIDTH-1:0] shift_p1;
  logic             ovf_p1;
  logic             vld_p1;

  shift_left_core #(
    .WIDTH (WIDTH),
    .SHAMT (SHAMT)
  ) u_core (
    .operand (mux3output),
    .result  (shift_p0),
    .ovf     (ovf_p0)
  );

  assign shift_out = shift_p0;

  // ---- p0 -> p1: capture the result and overflow on valid, hold otherwise.
  // The valid flag follows in_valid; a non-1 in_valid counts as 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_p1 <= '0;
      ovf_p1   <= 1'b0;
      vld_p1   <= 1'b0;
    end else if (in_valid) begin
      shift_p1 <= shift_p0;
      ovf_p1   <= ovf_p0;
      vld_p1   <= 1'b1;
    end else begin
      vld_p1   <= 1'b0;
    end
  end

  assign shift_out_q = shift_p1;
  assign ovf_q       = ovf_p1;
  assign out_valid   = vld_p1;

endmodule : shift_left

// File: tb/tb_shift_left.sv
// Testbench for shift_left. It runs directed cases and then a random sweep
// against an arithmetic reference model (multiply by 2**SHAMT, keep 16 bits).
module tb_shift_left;
  import shift_pkg::*;

  localparam int W  = WORD_W;
  localparam int SH = 1;

  logic  clk = 1'b0;
  logic  rst_n;
  word_t x;
  logic  v;

  word_t so1, soq1;
  logic  ov1, ovq1;
  word_t so0, soq0;
  logic  ov0, ovq0;

  int checks = 0;
  int errors = 0;

  word_t exp_q1, exp_q0;
  logic  exp_o1, exp_v;

  always #5 clk = ~clk;

  shift_left #(.WIDTH(W), .SHAMT(SH)) dut (
    .clk(clk), .rst_n(rst_n), .mux3output(x), .in_valid(v),
    .shift_out(so1), .shift_out_q(soq1), .out_valid(ov1), .ovf_q(ovq1)
  );

  shift_left #(.WIDTH(W), .SHAMT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .mux3output(x), .in_valid(v),
    .shift_out(so0), .shift_out_q(soq0), .out_valid(ov0), .ovf_q(ovq0)
  );

  // Reference: scale by 2**sh with plain integer arithmetic.
  function automatic word_t ref_val(input word_t a, input int sh);
    int unsigned p;
    p = int'(a) * (32'd1 << sh);
    return p[W-1:0];
  endfunction

  function automatic logic ref_ovf(input word_t a, input int sh);
    int unsigned p;
    p = int'(a) * (32'd1 << sh);
    return p >= (32'd1 << W);
  endfunction

  task automatic chk(input string tag, input word_t obs, input word_t exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    x     = '0;
    v     = 1'b0;

    // Reset state, before any clock edge.
    #2;
    chk("rst_q", soq1, 16'h0000);
    chk("rst_ovf", {15'd0, ovq1}, 16'h0000);
    chk("rst_vld", {15'd0, ov1}, 16'h0000);

    @(negedge clk);
    rst_n = 1'b1;

    // Combinational path.
    x = 16'd10; #1;
    chk("comb_10", so1, 16'd20);
    x = 16'd12; #1;
    chk("comb_12", so1, 16'd24);

    // MSB drop with overflow.
    @(negedge clk);
    x = 16'h8001; v = 1'b1; #1;
    chk("comb_8001", so1, 16'h0002);
    @(posedge clk); #1;
    chk("q_8001", soq1, 16'h0002);
    chk("ovf_8001", {15'd0, ovq1}, 16'h0001);
    chk("vld_8001", {15'd0, ov1}, 16'h0001);

    // All ones, then hold while in_valid is low.
    @(negedge clk);
    x = 16'hFFFF; v = 1'b1;
    @(posedge clk); #1;
    chk("q_ffff", soq1, 16'hFFFE);
    @(negedge clk);
    x = 16'h0005; v = 1'b0;
    @(posedge clk); #1;
    chk("hold_q", soq1, 16'hFFFE);
    chk("hold_vld", {15'd0, ov1}, 16'h0000);
    chk("hold_ovf", {15'd0, ovq1}, 16'h0001);

    // SHAMT=0 instance.
    @(negedge clk);
    x = 16'h1234; v = 1'b1; #1;
    chk("sh0_comb", so0, 16'h1234);
    @(posedge clk); #1;
    chk("sh0_q", soq0, 16'h1234);
    chk("sh0_ovf", {15'd0, ovq0}, 16'h0000);

    // Asynchronous reset between edges; combinational output stays live.
    @(negedge clk);
    #2;
    rst_n = 1'b0; #1;
    chk("arst_q", soq1, 16'h0000);
    chk("arst_ovf", {15'd0, ovq1}, 16'h0000);
    chk("arst_vld", {15'd0, ov1}, 16'h0000);
    chk("arst_comb", so1, 16'h2468);

    // Release mid-stream: the first edge samples normally.
    x = 16'h0003; v = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rel_q", soq1, 16'h0006);
    chk("rel_vld", {15'd0, ov1}, 16'h0001);

    // Random sweep against the reference model.
    exp_q1 = 16'h0006;
    exp_o1 = 1'b0;
    exp_q0 = 16'h0003;
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      x = word_t'($urandom);
      v = ($urandom_range(0, 3) != 0);
      #1;
      chk("rnd_comb1", so1, ref_val(x, SH));
      chk("rnd_comb0", so0, ref_val(x, 0));
      if (v) begin
        exp_q1 = ref_val(x, SH);
        exp_o1 = ref_ovf(x, SH);
        exp_q0 = x;
      end
      exp_v = v;
      @(posedge clk); #1;
      chk("rnd_q1", soq1, exp_q1);
      chk("rnd_ovf1", {15'd0, ovq1}, {15'd0, exp_o1});
      chk("rnd_vld", {15'd0, ov1}, {15'd0, exp_v});
      chk("rnd_q0", soq0, exp_q0);
      chk("rnd_ovf0", {15'd0, ovq0}, 16'h0000);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_shift_left
